// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and coordinate type shared by the VGA sync blocks.
package vga_timing_pkg;

    localparam int unsigned CoordW = 10;
    typedef logic [CoordW-1:0] coord_t;

    localparam int unsigned DefHDisplay = 640;
    localparam int unsigned DefHFront   = 16;
    localparam int unsigned DefHSync    = 96;
    localparam int unsigned DefHBack    = 48;
    localparam int unsigned DefVDisplay = 480;
    localparam int unsigned DefVFront   = 10;
    localparam int unsigned DefVSync    = 2;
    localparam int unsigned DefVBack    = 33;

    localparam int unsigned DefHTotal = DefHDisplay + DefHFront + DefHSync + DefHBack;
    localparam int unsigned DefVTotal = DefVDisplay + DefVFront + DefVSync + DefVBack;

    localparam int unsigned DefHSyncStart = DefHDisplay + DefHFront;
    localparam int unsigned DefHSyncEnd   = DefHDisplay + DefHFront + DefHSync - 1;
    localparam int unsigned DefVSyncStart = DefVDisplay + DefVFront;
    localparam int unsigned DefVSyncEnd   = DefVDisplay + DefVFront + DefVSync - 1;

    function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Video timing bundle from vga_sync_gen to the pixel generator and sync pins.
// frame_tick exists only when VGA_FRAME_TICK_EN is defined.
interface vga_sync_gen_if;
    import vga_timing_pkg::*;

    logic   p_tick;
    coord_t x;
    coord_t y;
    logic   hsync;
    logic   vsync;
    logic   video_on;
`ifdef VGA_FRAME_TICK_EN
    logic   frame_tick;

    modport master (
        output p_tick, x, y, hsync, vsync, video_on, frame_tick
    );
    modport slave (
        input  p_tick, x, y, hsync, vsync, video_on, frame_tick
    );
`else
    modport master (
        output p_tick, x, y, hsync, vsync, video_on
    );
    modport slave (
        input  p_tick, x, y, hsync, vsync, video_on
    );
`endif

endinterface

// File: rtl/pixel_tick_div.sv
// Clock-enable divider: registered p_tick, one clk wide, every CLK_DIV clks (CLK_DIV 1..16).
module pixel_tick_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

    logic [DivW-1:0] div_cnt_q, div_cnt_d;
    logic            p_tick_q, p_tick_d;

    // Registering from the next count puts p_tick high while div_cnt sits at CLK_DIV-1.
    always_comb begin
        div_cnt_d = (div_cnt_q == DivLast) ? '0 : div_cnt_q + 1'b1;
        p_tick_d  = (div_cnt_d == DivLast);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
            p_tick_q  <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            p_tick_q  <= p_tick_d;
        end
    end

    assign p_tick = p_tick_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel enable, x/y counters, registered syncs and video_on.
// Define VGA_FRAME_TICK_EN to add a once-per-frame frame_tick at (0, V_DISPLAY+1).
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_DISPLAY       = DefHDisplay,
    parameter int unsigned H_FRONT         = DefHFront,
    parameter int unsigned H_SYNC          = DefHSync,
    parameter int unsigned H_BACK          = DefHBack,
    parameter int unsigned V_DISPLAY       = DefVDisplay,
    parameter int unsigned V_FRONT         = DefVFront,
    parameter int unsigned V_SYNC          = DefVSync,
    parameter int unsigned V_BACK          = DefVBack,
    parameter int unsigned CLK_DIV         = 4,
    parameter int unsigned SYNC_ACTIVE_LOW = 1
) (
    input  logic           clk,
    input  logic           reset,
    vga_sync_gen_if.master vga
);

    localparam int unsigned HTotal = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned VTotal = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t HLast      = coord_t'(HTotal - 1);
    localparam coord_t VLast      = coord_t'(VTotal - 1);
    localparam coord_t HDisp      = coord_t'(H_DISPLAY);
    localparam coord_t VDisp      = coord_t'(V_DISPLAY);
    localparam coord_t HSyncStart = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t HSyncEnd   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam coord_t VSyncStart = coord_t'(V_DISPLAY + V_FRONT);
    localparam coord_t VSyncEnd   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    localparam logic SyncAct  = (SYNC_ACTIVE_LOW == 0);
    localparam logic SyncIdle = ~SyncAct;

    logic   p_tick;
    coord_t h_cnt_q, h_cnt_d;
    coord_t v_cnt_q, v_cnt_d;
    logic   hsync_q, hsync_d;
    logic   vsync_q, vsync_d;

    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick_div (
        .clk    (clk),
        .reset  (reset),
        .p_tick (p_tick)
    );

    // Syncs are decoded from the next-state counters so their edges line up with x/y.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (p_tick) begin
            if (h_cnt_q == HLast) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == VLast) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
        hsync_d = in_window(h_cnt_d, HSyncStart, HSyncEnd) ? SyncAct : SyncIdle;
        vsync_d = in_window(v_cnt_d, VSyncStart, VSyncEnd) ? SyncAct : SyncIdle;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            hsync_q <= SyncIdle;
            vsync_q <= SyncIdle;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

`ifdef VGA_FRAME_TICK_EN
    localparam coord_t FrameTickLine = coord_t'(V_DISPLAY + 1);

    logic frame_tick_q, frame_tick_d;

    always_comb begin
        frame_tick_d = p_tick && (h_cnt_d == '0) && (v_cnt_d == FrameTickLine);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_tick_q <= 1'b0;
        end else begin
            frame_tick_q <= frame_tick_d;
        end
    end

    assign vga.frame_tick = frame_tick_q;
`endif

    assign vga.p_tick   = p_tick;
    assign vga.x        = h_cnt_q;
    assign vga.y        = v_cnt_q;
    assign vga.hsync    = hsync_q;
    assign vga.vsync    = vsync_q;
    assign vga.video_on = (h_cnt_q < HDisp) && (v_cnt_q < VDisp);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench: DUT A is the default 640x480 build; DUT B shrinks the line to 16 pixels, CLK_DIV=1 and
// active-high syncs so whole frames fit in a short run.
module tb_vga_sync_gen;
    import vga_timing_pkg::*;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    always #5 clk = ~clk;

    vga_sync_gen_if if_a ();
    vga_sync_gen_if if_b ();

    vga_sync_gen u_dut_a (
        .clk   (clk),
        .reset (rst_a),
        .vga   (if_a)
    );

    vga_sync_gen #(
        .H_DISPLAY       (8),
        .H_FRONT         (2),
        .H_SYNC          (3),
        .H_BACK          (3),
        .CLK_DIV         (1),
        .SYNC_ACTIVE_LOW (0)
    ) u_dut_b (
        .clk   (clk),
        .reset (rst_b),
        .vga   (if_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Vectors for DUT A: k = clk edges since reset release.
    typedef struct {
        int unsigned k;
        int unsigned x;
        int unsigned y;
        bit          hs;
        bit          vs;
        bit          von;
        bit          pt;
    } vec_t;

    vec_t vecs[16];

    // Scoreboard for DUT B.
    typedef struct {
        int unsigned x;
        int unsigned y;
        bit          hs;
        bit          vs;
        bit          von;
        bit          ft;
    } exp_t;

    exp_t        sbq[$];
    bit          sb_en = 1'b0;
    int unsigned n_pix = 0;
    int unsigned sb_pops = 0;
    int unsigned cyc_b = 0;
    int unsigned last_origin = 0;
    int unsigned origins = 0;
    int unsigned vs_cnt = 0;
    int unsigned ft_cnt = 0;
    bit          prev_origin = 1'b0;

    function automatic exp_t model_b(input int unsigned n);
        exp_t e;
        e.x   = n % 16;
        e.y   = (n / 16) % 525;
        e.hs  = (e.x >= 10) && (e.x <= 12);
        e.vs  = (e.y >= 490) && (e.y <= 491);
        e.von = (e.x < 8) && (e.y < 480);
        e.ft  = (e.x == 0) && (e.y == 481);
        return e;
    endfunction

    always @(negedge clk) begin
        if (sb_en) begin
            exp_t e;
            bit   at_origin;
            cyc_b++;
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                sb_pops++;
                check("sb x", if_b.x, e.x);
                check("sb y", if_b.y, e.y);
                check("sb hsync", if_b.hsync, e.hs);
                check("sb vsync", if_b.vsync, e.vs);
                check("sb video_on", if_b.video_on, e.von);
`ifdef VGA_FRAME_TICK_EN
                check("sb frame_tick", if_b.frame_tick, e.ft);
`endif
            end
            if (if_b.p_tick) begin
                n_pix++;
                sbq.push_back(model_b(n_pix));
            end
            if (if_b.vsync) vs_cnt++;
`ifdef VGA_FRAME_TICK_EN
            if (if_b.frame_tick) ft_cnt++;
`endif
            at_origin = (if_b.x == 0) && (if_b.y == 0);
            if (at_origin && !prev_origin) begin
                if (origins >= 2) begin
                    check("frame length", cyc_b - last_origin, 16 * 525);
                    check("vsync clks per frame", vs_cnt, 2 * 16);
`ifdef VGA_FRAME_TICK_EN
                    check("frame_ticks per frame", ft_cnt, 1);
`endif
                end
                origins++;
                last_origin = cyc_b;
                vs_cnt = 0;
                ft_cnt = 0;
            end
            prev_origin = at_origin;
        end
    end

    initial begin
        int unsigned k_now;
        int          budget;
        int          cnt;

        vecs[0]  = '{k: 0,     x: 0,   y: 0,  hs: 1, vs: 1, von: 1, pt: 0};
        vecs[1]  = '{k: 2,     x: 0,   y: 0,  hs: 1, vs: 1, von: 1, pt: 0};
        vecs[2]  = '{k: 3,     x: 0,   y: 0,  hs: 1, vs: 1, von: 1, pt: 1};
        vecs[3]  = '{k: 4,     x: 1,   y: 0,  hs: 1, vs: 1, von: 1, pt: 0};
        vecs[4]  = '{k: 7,     x: 1,   y: 0,  hs: 1, vs: 1, von: 1, pt: 1};
        vecs[5]  = '{k: 8,     x: 2,   y: 0,  hs: 1, vs: 1, von: 1, pt: 0};
        vecs[6]  = '{k: 2559,  x: 639, y: 0,  hs: 1, vs: 1, von: 1, pt: 1};
        vecs[7]  = '{k: 2560,  x: 640, y: 0,  hs: 1, vs: 1, von: 0, pt: 0};
        vecs[8]  = '{k: 2623,  x: DefHSyncStart - 1, y: 0, hs: 1, vs: 1, von: 0, pt: 1};
        vecs[9]  = '{k: 2624,  x: DefHSyncStart, y: 0, hs: 0, vs: 1, von: 0, pt: 0};
        vecs[10] = '{k: 3007,  x: DefHSyncEnd, y: 0, hs: 0, vs: 1, von: 0, pt: 1};
        vecs[11] = '{k: 3008,  x: DefHSyncEnd + 1, y: 0, hs: 1, vs: 1, von: 0, pt: 0};
        vecs[12] = '{k: 3199,  x: DefHTotal - 1, y: 0, hs: 1, vs: 1, von: 0, pt: 1};
        vecs[13] = '{k: 3200,  x: 0,   y: 1,  hs: 1, vs: 1, von: 1, pt: 0};
        vecs[14] = '{k: 34559, x: 639, y: 10, hs: 1, vs: 1, von: 1, pt: 1};
        vecs[15] = '{k: 34560, x: 640, y: 10, hs: 1, vs: 1, von: 0, pt: 0};

        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(posedge clk);

        // DUT A: table-driven checks from reset release.
        @(negedge clk);
        rst_a = 1'b0;
        #1;
        k_now = 0;
        foreach (vecs[i]) begin
            repeat (vecs[i].k - k_now) @(negedge clk);
            k_now = vecs[i].k;
            check($sformatf("A v%0d x", i), if_a.x, vecs[i].x);
            check($sformatf("A v%0d y", i), if_a.y, vecs[i].y);
            check($sformatf("A v%0d hsync", i), if_a.hsync, vecs[i].hs);
            check($sformatf("A v%0d vsync", i), if_a.vsync, vecs[i].vs);
            check($sformatf("A v%0d video_on", i), if_a.video_on, vecs[i].von);
            check($sformatf("A v%0d p_tick", i), if_a.p_tick, vecs[i].pt);
        end

        // DUT A: reset in the middle of hsync.
        budget = 4000;
        while (if_a.x != 700 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("A reach x=700", (budget > 0), 1);
        check("A hsync active pre-reset", if_a.hsync, 0);
        rst_a = 1'b1;
        #1;
        check("A rst x", if_a.x, 0);
        check("A rst y", if_a.y, 0);
        check("A rst hsync", if_a.hsync, 1);
        check("A rst vsync", if_a.vsync, 1);
        check("A rst video_on", if_a.video_on, 1);
        check("A rst p_tick", if_a.p_tick, 0);
        @(negedge clk);
        rst_a = 1'b0;
        cnt = 0;
        while (!if_a.p_tick && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("A first p_tick after reset", cnt, 3);
        @(negedge clk);
        check("A x after restart", if_a.x, 1);

        // DUT B: scoreboard over multiple frames, then reset with both syncs active.
        @(negedge clk);
        #1;
        rst_b = 1'b0;
        sb_en = 1'b1;
        budget = 40000;
        while (!(if_b.x == 11 && if_b.y == 491 && origins >= 3) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("B reach (11,491)", (budget > 0), 1);
        #1;
        check("B hsync active pre-reset", if_b.hsync, 1);
        check("B vsync active pre-reset", if_b.vsync, 1);
        sb_en = 1'b0;
        rst_b = 1'b1;
        #1;
        check("B rst x", if_b.x, 0);
        check("B rst y", if_b.y, 0);
        check("B rst hsync", if_b.hsync, 0);
        check("B rst vsync", if_b.vsync, 0);
        check("B rst video_on", if_b.video_on, 1);
        check("B rst p_tick", if_b.p_tick, 0);
        sbq.delete();
        n_pix = 0;
        cyc_b = 0;
        origins = 0;
        prev_origin = 1'b0;
        @(negedge clk);
        #1;
        rst_b = 1'b0;
        sb_en = 1'b1;
        cnt = 0;
        while (!if_b.p_tick && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("B first p_tick after reset", cnt, 1);
        repeat (200) @(negedge clk);
        check("B scoreboard active", (sb_pops > 20000), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
